// File: rtl/igmv_param.sv
// igmv_param: parametrised signed integer matrix-vector multiplier, OUT = M x V.
// Operands stream column by column from synchronous-read memories sharing ADDR.
// A single FSM sequences fetch, drain and result load behind an ST/RD handshake.
// Optional feature macro: IGMV_SAT_EN adds per-lane output clamping and a sticky
// SAT flag; without it each result is the low DATA_WIDTH bits of its accumulator.
module igmv_param #(
  parameter int ROWS          = 10,
  parameter int COLS          = 10,
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 4,
  parameter int ACC_WIDTH     = 2*DATA_WIDTH + $clog2(COLS) + 1
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         ST,
  input  logic [DATA_WIDTH-1:0]        DATA1,
  input  logic [ROWS*DATA_WIDTH-1:0]   DATA2,
  output logic [ADDRESS_WIDTH-1:0]     ADDR,
  output logic                         Read,
  output logic [ROWS*DATA_WIDTH-1:0]   OUT,
  output logic                         RD
`ifdef IGMV_SAT_EN
  ,
  output logic                         SAT
`endif
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(COLS - 1);

  state_t                       state;
  logic                         valid;     // memory data on DATA1/DATA2 belongs to this run
  logic                         start_ok;  // ST accepted this cycle
  logic signed [ACC_WIDTH-1:0]  v_ext;
  logic [ROWS*DATA_WIDTH-1:0]   conv;      // per-lane converted results, ready to load

`ifdef IGMV_SAT_EN
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;
  logic [ROWS-1:0]              clamp;
`endif

  // Starts are only honoured when no run is in flight; busy-time ST is dropped.
  assign start_ok = ST && ((state == IDLE) || (state == DONE));
  assign v_ext    = ACC_WIDTH'($signed(DATA1));

  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] m_ext;
    logic signed [ACC_WIDTH-1:0] prod;

    // Both factors are widened first so the product is formed at full accumulator width.
    assign m_ext = ACC_WIDTH'($signed(DATA2[r*DATA_WIDTH +: DATA_WIDTH]));
    assign prod  = m_ext * v_ext;

    // Lane accumulator: cleared on an accepted start, one MAC per valid memory beat.
    // NOTE: datapath registers share the async reset so a mid-run reset can never
    // leave a stale partial sum that a later run would pick up.
    always_ff @(posedge CLK or negedge RST) begin
      if (!RST)          acc <= '0;
      else if (start_ok) acc <= '0;
      else if (valid)    acc <= acc + prod;
    end

`ifdef IGMV_SAT_EN
    assign clamp[r] = (acc > SAT_MAX) || (acc < SAT_MIN);
    assign conv[r*DATA_WIDTH +: DATA_WIDTH] =
      (acc > SAT_MAX) ? SAT_MAX[DATA_WIDTH-1:0] :
      (acc < SAT_MIN) ? SAT_MIN[DATA_WIDTH-1:0] :
                        acc[DATA_WIDTH-1:0];
`else
    assign conv[r*DATA_WIDTH +: DATA_WIDTH] = acc[DATA_WIDTH-1:0];
`endif
  end

  // Control FSM with registered memory interface, result register and ready flag.
  // NOTE: every register here uses <= so all of them update from the same
  // pre-edge values; a blocking assignment would leak new values into later lines.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
      ADDR  <= '0;
      Read  <= 1'b0;
      valid <= 1'b0;
      RD    <= 1'b0;
      OUT   <= '0;
`ifdef IGMV_SAT_EN
      SAT   <= 1'b0;
`endif
    end else begin
      // Data arrives one cycle after the read request.
      valid <= Read;
      case (state)
        IDLE, DONE: begin
          if (ST) begin
            ADDR  <= '0;
            Read  <= 1'b1;
            RD    <= 1'b0;
`ifdef IGMV_SAT_EN
            SAT   <= 1'b0;
`endif
            state <= FETCH;
          end
        end
        FETCH: begin
          if (ADDR == LAST_ADDR) begin
            Read  <= 1'b0;
            state <= DRAIN;
          end else begin
            ADDR  <= ADDR + 1'b1;
          end
        end
        DRAIN: begin
          // While valid is high the final column is still being accumulated;
          // once it drops the accumulators are complete and can be published.
          if (!valid) begin
            OUT   <= conv;
            RD    <= 1'b1;
`ifdef IGMV_SAT_EN
            SAT   <= |clamp;
`endif
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_igmv_param.sv
// Directed testbench for igmv_param: a 2x3x16-bit instance and a 1x1 edge-size
// instance, each fed by a synchronous-read memory model with one-cycle latency.
module tb_igmv_param;

  localparam int R  = 2;
  localparam int C  = 3;
  localparam int DW = 16;
  localparam int AW = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic st    = 1'b0;
  logic st_s  = 1'b0;

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Main instance signals and memories.
  logic [DW-1:0]        data1;
  logic [R*DW-1:0]      data2;
  logic [AW-1:0]        addr;
  logic                 read;
  logic [R*DW-1:0]      out;
  logic                 rd;
  logic signed [DW-1:0] vmem [4];
  logic signed [DW-1:0] mmem [R][4];

  // Edge-size instance signals and memories.
  logic [DW-1:0]        data1_s;
  logic [DW-1:0]        data2_s;
  logic [0:0]           addr_s;
  logic                 read_s;
  logic [DW-1:0]        out_s;
  logic                 rd_s;
  logic signed [DW-1:0] vmem_s [2];
  logic signed [DW-1:0] mmem_s [2];

`ifdef IGMV_SAT_EN
  logic sat;
  logic sat_s;
`endif

  igmv_param #(.ROWS(R), .COLS(C), .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) u_dut (
    .CLK(clk), .RST(rst_n), .ST(st), .DATA1(data1), .DATA2(data2),
    .ADDR(addr), .Read(read), .OUT(out), .RD(rd)
`ifdef IGMV_SAT_EN
    , .SAT(sat)
`endif
  );

  igmv_param #(.ROWS(1), .COLS(1), .DATA_WIDTH(DW), .ADDRESS_WIDTH(1)) u_small (
    .CLK(clk), .RST(rst_n), .ST(st_s), .DATA1(data1_s), .DATA2(data2_s),
    .ADDR(addr_s), .Read(read_s), .OUT(out_s), .RD(rd_s)
`ifdef IGMV_SAT_EN
    , .SAT(sat_s)
`endif
  );

  // Synchronous-read memory models: data valid one cycle after Read/ADDR.
  always @(posedge clk) begin
    if (read) begin
      data1 <= vmem[addr];
      for (int r = 0; r < R; r++) data2[r*DW +: DW] <= mmem[r][addr];
    end
    if (read_s) begin
      data1_s <= vmem_s[addr_s];
      data2_s <= mmem_s[addr_s];
    end
  end

  task automatic load_basic();
    vmem[0] = 16'sd1;  vmem[1] = 16'sd2; vmem[2] = 16'sd3;
    mmem[0][0] = 16'sd4;  mmem[0][1] = 16'sd5; mmem[0][2] = 16'sd6;
    mmem[1][0] = -16'sd1; mmem[1][1] = 16'sd0; mmem[1][2] = 16'sd2;
  endtask

  // One operation on the main instance, checked cycle by cycle from the ST edge.
  // o1/o0: result expected to be held before reload; e1/e0: new result.
  task automatic run_big(input string name, input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                         input logic [DW-1:0] o0, input logic [DW-1:0] o1,
                         input bit esat, input bit busy);
    logic [AW-1:0] exp_addr;
    @(negedge clk);
    st = 1'b1;
    @(posedge clk);
    for (int j = 0; j <= C + 2; j++) begin
      @(negedge clk);
      exp_addr = (j < C) ? AW'(j) : AW'(C - 1);
      tests++;
      if (read !== (j < C)) begin
        fails++; $display("FAIL %s read j=%0d: got %b want %b", name, j, read, (j < C));
      end
      tests++;
      if (addr !== exp_addr) begin
        fails++; $display("FAIL %s addr j=%0d: got %0d want %0d", name, j, addr, exp_addr);
      end
      tests++;
      if (rd !== (j == C + 2)) begin
        fails++; $display("FAIL %s rd j=%0d: got %b want %b", name, j, rd, (j == C + 2));
      end
      tests++;
      if (j < C + 2) begin
        if (out !== {o1, o0}) begin
          fails++; $display("FAIL %s held out j=%0d: got %h want %h", name, j, out, {o1, o0});
        end
      end else begin
        if (out !== {e1, e0}) begin
          fails++; $display("FAIL %s result out: got %h want %h", name, out, {e1, e0});
        end
      end
`ifdef IGMV_SAT_EN
      tests++;
      if (sat !== ((j == C + 2) ? esat : 1'b0)) begin
        fails++; $display("FAIL %s sat j=%0d: got %b want %b", name, j, sat,
                          (j == C + 2) ? esat : 1'b0);
      end
`endif
      st = (j == 0) ? busy : 1'b0;
    end
    // A result must stay put with no further reads once DONE is reached.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests++;
      if (rd !== 1'b1 || read !== 1'b0 || out !== {e1, e0}) begin
        fails++; $display("FAIL %s done hold k=%0d: got rd=%b read=%b out=%h want rd=1 read=0 out=%h",
                          name, k, rd, read, out, {e1, e0});
      end
    end
    if (esat) begin end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (addr !== '0 || read !== 1'b0 || rd !== 1'b0 || out !== '0) begin
      fails++; $display("FAIL reset main: got addr=%0d read=%b rd=%b out=%h want all 0",
                        addr, read, rd, out);
    end
    tests++;
    if (addr_s !== '0 || read_s !== 1'b0 || rd_s !== 1'b0 || out_s !== '0) begin
      fails++; $display("FAIL reset small: got addr=%0d read=%b rd=%b out=%h want all 0",
                        addr_s, read_s, rd_s, out_s);
    end
`ifdef IGMV_SAT_EN
    tests++;
    if (sat !== 1'b0 || sat_s !== 1'b0) begin
      fails++; $display("FAIL reset sat: got %b/%b want 0/0", sat, sat_s);
    end
`endif
    rst_n = 1'b1;
  endtask

  task automatic test_edge_size();
    vmem_s[0] = -16'sd3; vmem_s[1] = 16'sd0;
    mmem_s[0] = 16'sd7;  mmem_s[1] = 16'sd0;
    @(negedge clk);
    st_s = 1'b1;
    @(posedge clk);
    for (int j = 0; j <= 3; j++) begin
      @(negedge clk);
      st_s = 1'b0;
      tests++;
      if (read_s !== (j == 0)) begin
        fails++; $display("FAIL edge read j=%0d: got %b want %b", j, read_s, (j == 0));
      end
      tests++;
      if (rd_s !== (j == 3)) begin
        fails++; $display("FAIL edge rd j=%0d: got %b want %b", j, rd_s, (j == 3));
      end
      tests++;
      if (out_s !== ((j == 3) ? 16'hFFEB : 16'h0000)) begin
        fails++; $display("FAIL edge out j=%0d: got %h want %h", j, out_s,
                          (j == 3) ? 16'hFFEB : 16'h0000);
      end
    end
  endtask

  task automatic test_basic();
    load_basic();
    run_big("basic", 16'd32, 16'd5, 16'd0, 16'd0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    vmem[0] = 16'sd0; vmem[1] = 16'sd0; vmem[2] = 16'sd1;
    run_big("back_to_back", 16'd6, 16'd2, 16'd32, 16'd5, 1'b0, 1'b0);
  endtask

  task automatic test_busy_start();
    load_basic();
    run_big("busy_start", 16'd32, 16'd5, 16'd6, 16'd2, 1'b0, 1'b1);
  endtask

  task automatic test_overflow();
    for (int c = 0; c < C; c++) begin
      vmem[c] = 16'sd200; mmem[0][c] = 16'sd200; mmem[1][c] = 16'sd0;
    end
`ifdef IGMV_SAT_EN
    run_big("overflow", 16'h7FFF, 16'd0, 16'd32, 16'd5, 1'b1, 1'b0);
`else
    run_big("overflow", 16'hD4C0, 16'd0, 16'd32, 16'd5, 1'b0, 1'b0);
`endif
  endtask

  task automatic test_reset_mid_run();
    load_basic();
    @(negedge clk);
    st = 1'b1;
    @(posedge clk);
    @(negedge clk);
    st = 1'b0;
    @(negedge clk);
    tests++;
    if (addr !== AW'(1) || read !== 1'b1) begin
      fails++; $display("FAIL midrun pre-reset: got addr=%0d read=%b want addr=1 read=1", addr, read);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if (addr !== '0 || read !== 1'b0 || rd !== 1'b0 || out !== '0) begin
      fails++; $display("FAIL midrun async reset: got addr=%0d read=%b rd=%b out=%h want all 0",
                        addr, read, rd, out);
    end
`ifdef IGMV_SAT_EN
    tests++;
    if (sat !== 1'b0) begin
      fails++; $display("FAIL midrun sat: got %b want 0", sat);
    end
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_big("after_reset", 16'd32, 16'd5, 16'd0, 16'd0, 1'b0, 1'b0);
  endtask

  initial begin
    for (int c = 0; c < 4; c++) begin
      vmem[c] = '0;
      for (int r = 0; r < R; r++) mmem[r][c] = '0;
    end
    test_reset();
    test_edge_size();
    test_basic();
    test_back_to_back();
    test_busy_start();
    test_overflow();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
